dbus_responder: RTL and testbench



---
 rtl/dbus_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_dbus_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder
//
// Responder end of the core's data-memory port. Holds the data RAM and a small
// MMIO window containing a GPIO output register and a machine timer
// (mtime / mtimecmp / prescaler) with a level interrupt.
//
// Reads are combinational (zero wait states) and always return the state as
// it was before any write in the same cycle. Writes commit at the rising clk
// edge, per byte lane. addr[1:0] is ignored: accesses are whole words.
//
// Address map (decoded independently for read and write addresses):
//   RAM  : addr[31:RAM_AW+2] == 0
//   MMIO : addr[31:12] == MMIO_BASE[31:12]
//            0x00 GPIO_OUT, 0x04 MTIME_LO, 0x08 MTIME_HI,
//            0x0C MTIMECMP_LO, 0x10 MTIMECMP_HI, 0x14 PRESCALE[15:0]
//   other: reads 0, writes ignored
//
// Configuration macro:
//   DBUS_TIMER_EN - when defined, the timer block (mtime, mtimecmp, PRESCALE,
//                   timer_irq_o) is built. When undefined, offsets 0x04-0x14
//                   read 0, ignore writes, and timer_irq_o is tied low.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   mem_raddr    read byte address
//   mem_waddr    write byte address
//   mem_wdata    write data
//   mem_we       byte-lane write enables (bit i writes byte i)
//   mem_rdata    read data (combinational)
//   gpio_o       GPIO output register
//   timer_irq_o  registered timer interrupt (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module dbus_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_o,
    output logic        timer_irq_o
);

    // MMIO register word indices (addr[11:2])
    localparam logic [9:0] IDX_GPIO   = 10'd0;
    localparam logic [9:0] IDX_MTLO   = 10'd1;
    localparam logic [9:0] IDX_MTHI   = 10'd2;
    localparam logic [9:0] IDX_CMPLO  = 10'd3;
    localparam logic [9:0] IDX_CMPHI  = 10'd4;
    localparam logic [9:0] IDX_PRESC  = 10'd5;

    // Byte-lane merge of new data over an old word
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  we
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // Everything above the RAM word index must be zero (covers addr[31:28] too)
    function automatic logic is_ram(input logic [31:0] addr);
        return (addr >> (RAM_AW + 2)) == 32'd0;
    endfunction

    function automatic logic is_mmio(input logic [31:0] addr);
        return addr[31:12] == MMIO_BASE[31:12];
    endfunction

    logic [31:0]       ram_r [2**RAM_AW];
    logic [RAM_AW-1:0] ram_widx_s;
    logic [RAM_AW-1:0] ram_ridx_s;
    logic [9:0]        widx_s;
    logic [9:0]        ridx_s;
    logic              any_we_s;
    logic              ram_wr_s;
    logic              mmio_wr_s;
    logic              wr_gpio_s;
    logic [31:0]       gpio_r;
    logic [31:0]       rdata_s;
    logic              unused_addr_lsb_s;

    assign ram_widx_s = mem_waddr[RAM_AW+1:2];
    assign ram_ridx_s = mem_raddr[RAM_AW+1:2];
    assign widx_s     = mem_waddr[11:2];
    assign ridx_s     = mem_raddr[11:2];
    assign any_we_s   = (mem_we != 4'b0000);
    assign ram_wr_s   = any_we_s && is_ram(mem_waddr);
    assign mmio_wr_s  = any_we_s && is_mmio(mem_waddr);
    assign wr_gpio_s  = mmio_wr_s && (widx_s == IDX_GPIO);

    // Byte offset within a word is irrelevant to this port
    assign unused_addr_lsb_s = ^{mem_raddr[1:0], mem_waddr[1:0]};

    // RAM byte-lane write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) begin
                    ram_r[ram_widx_s][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // GPIO output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_r <= 32'd0;
        end else if (wr_gpio_s) begin
            gpio_r <= merge_bytes(gpio_r, mem_wdata, mem_we);
        end
    end

    assign gpio_o = gpio_r;

`ifdef DBUS_TIMER_EN
    logic [63:0] mtime_r;
    logic [63:0] mtime_nxt_s;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtimecmp_nxt_s;
    logic [15:0] prescale_r;
    logic [15:0] prescale_nxt_s;
    logic [15:0] pcnt_r;
    logic [15:0] pcnt_nxt_s;
    logic        irq_r;
    logic        tick_s;
    logic        wr_mtlo_s;
    logic        wr_mthi_s;
    logic        wr_cmplo_s;
    logic        wr_cmphi_s;
    logic        wr_presc_s;

    assign wr_mtlo_s  = mmio_wr_s && (widx_s == IDX_MTLO);
    assign wr_mthi_s  = mmio_wr_s && (widx_s == IDX_MTHI);
    assign wr_cmplo_s = mmio_wr_s && (widx_s == IDX_CMPLO);
    assign wr_cmphi_s = mmio_wr_s && (widx_s == IDX_CMPHI);
    assign wr_presc_s = mmio_wr_s && (widx_s == IDX_PRESC);
    assign tick_s     = (pcnt_r == prescale_r);

    // Timer next-state: a software write to either mtime half beats the tick
    // and freezes the other half for that cycle
    always_comb begin
        mtime_nxt_s    = mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        prescale_nxt_s = prescale_r;
        pcnt_nxt_s     = pcnt_r + 16'd1;

        if (wr_mtlo_s) begin
            mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], mem_wdata, mem_we);
        end else if (wr_mthi_s) begin
            mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], mem_wdata, mem_we);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end

        if (wr_cmplo_s) begin
            mtimecmp_nxt_s[31:0] = merge_bytes(mtimecmp_r[31:0], mem_wdata, mem_we);
        end else if (wr_cmphi_s) begin
            mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], mem_wdata, mem_we);
        end else begin
            mtimecmp_nxt_s = mtimecmp_r;
        end

        // Any write to PRESCALE restarts the prescale count
        if (wr_presc_s) begin
            prescale_nxt_s[7:0]  = mem_we[0] ? mem_wdata[7:0]  : prescale_r[7:0];
            prescale_nxt_s[15:8] = mem_we[1] ? mem_wdata[15:8] : prescale_r[15:8];
            pcnt_nxt_s           = 16'd0;
        end else if (tick_s) begin
            pcnt_nxt_s = 16'd0;
        end else begin
            pcnt_nxt_s = pcnt_r + 16'd1;
        end
    end

    // Timer state registers and registered compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_r <= 16'd0;
            pcnt_r     <= 16'd0;
            irq_r      <= 1'b0;
        end else begin
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            prescale_r <= prescale_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            irq_r      <= (mtime_r >= mtimecmp_r);
        end
    end

    assign timer_irq_o = irq_r;
`else
    assign timer_irq_o = 1'b0;
`endif

    // Read mux: current register/RAM state, no write forwarding
    always_comb begin
        rdata_s = 32'd0;
        if (is_ram(mem_raddr)) begin
            rdata_s = ram_r[ram_ridx_s];
        end else if (is_mmio(mem_raddr)) begin
            case (ridx_s)
                IDX_GPIO:  rdata_s = gpio_r;
`ifdef DBUS_TIMER_EN
                IDX_MTLO:  rdata_s = mtime_r[31:0];
                IDX_MTHI:  rdata_s = mtime_r[63:32];
                IDX_CMPLO: rdata_s = mtimecmp_r[31:0];
                IDX_CMPHI: rdata_s = mtimecmp_r[63:32];
                IDX_PRESC: rdata_s = {16'd0, prescale_r};
`endif
                default:   rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign mem_rdata = rdata_s;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: a table of single-cycle vectors for
// RAM / GPIO / decode behaviour, then hand-written timer, IRQ and reset
// sequences. Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dbus_responder;

    localparam logic [31:0] A_GPIO  = 32'h1000_0000;
    localparam logic [31:0] A_MTLO  = 32'h1000_0004;
    localparam logic [31:0] A_MTHI  = 32'h1000_0008;
    localparam logic [31:0] A_CMPLO = 32'h1000_000C;
    localparam logic [31:0] A_CMPHI = 32'h1000_0010;
    localparam logic [31:0] A_PRE   = 32'h1000_0014;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] gpio_o;
    logic        timer_irq_o;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_gpio;
    } vec_t;

    vec_t vecs[16];

    dbus_responder #(
        .RAM_AW    (12),
        .MMIO_BASE (32'h1000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_raddr   (mem_raddr),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .gpio_o      (gpio_o),
        .timer_irq_o (timer_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle's inputs and let the combinational read settle
    task automatic drive(input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] we, input logic [31:0] ra);
        mem_waddr = wa;
        mem_wdata = wd;
        mem_we    = we;
        mem_raddr = ra;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        mem_raddr = 32'd0;
        mem_waddr = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 4'd0;

        //            waddr          wdata          we       raddr          exp_rdata      exp_gpio
        vecs[0]  = '{32'h0000_0040, 32'hAABB_CCDD, 4'b1111, A_GPIO,        32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0040, 32'h1122_3344, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD, 32'h0000_0000};
        vecs[2]  = '{32'h0000_0080, 32'h0000_0000, 4'b1111, 32'h0000_0040, 32'hAA22_CC44, 32'h0000_0000};
        vecs[3]  = '{32'h0000_0080, 32'h5A5A_5A5A, 4'b1111, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{32'h2000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0080, 32'h5A5A_5A5A, 32'h0000_0000};
        vecs[5]  = '{32'h1000_0040, 32'h1234_5678, 4'b1111, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{A_GPIO,        32'h0000_00FF, 4'b0001, 32'h1000_0040, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{32'h0000_0040, 32'hDEAD_BEEF, 4'b0000, A_GPIO,        32'h0000_00FF, 32'h0000_00FF};
        vecs[8]  = '{A_GPIO,        32'h1234_5678, 4'b1000, 32'h0000_0043, 32'hAA22_CC44, 32'h0000_00FF};
        vecs[9]  = '{32'h0000_4040, 32'h0000_0000, 4'b1111, 32'h1000_0002, 32'h1200_00FF, 32'h1200_00FF};
        vecs[10] = '{32'h1000_0018, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0040, 32'hAA22_CC44, 32'h1200_00FF};
        vecs[11] = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_4040, 32'h0000_0000, 32'h1200_00FF};
        vecs[12] = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h1000_0018, 32'h0000_0000, 32'h1200_00FF};
        vecs[13] = '{32'h0FFF_FFFC, 32'h0000_0001, 4'b1111, 32'h0000_0080, 32'h5A5A_5A5A, 32'h1200_00FF};
        vecs[14] = '{32'h0000_3FFC, 32'h0BAD_F00D, 4'b1111, 32'h0FFF_FFFC, 32'h0000_0000, 32'h1200_00FF};
        vecs[15] = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_3FFC, 32'h0BAD_F00D, 32'h1200_00FF};

        // Reset state
        drive(32'd0, 32'd0, 4'd0, A_GPIO);
        check("rst_gpio", gpio_o, 32'd0);
        check("rst_irq", {31'd0, timer_irq_o}, 32'd0);
        check("rst_rd_gpio", mem_rdata, 32'd0);
        mem_raddr = A_CMPLO;
        #1;
`ifdef DBUS_TIMER_EN
        check("rst_rd_cmplo", mem_rdata, 32'hFFFF_FFFF);
`else
        check("rst_rd_cmplo", mem_rdata, 32'h0000_0000);
`endif
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Table of single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].waddr, vecs[i].wdata, vecs[i].we, vecs[i].raddr);
            check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_gpio", i), gpio_o, vecs[i].exp_gpio);
            check($sformatf("vec%0d_irq", i), {31'd0, timer_irq_o}, 32'd0);
            @(negedge clk);
        end

`ifdef DBUS_TIMER_EN
        // Prescale: PRESCALE=3 gives one mtime tick every 4 cycles
        drive(A_MTHI, 32'd0, 4'b1111, A_PRE);
        check("pre_init", mem_rdata, 32'd0);
        @(negedge clk);
        drive(A_PRE, 32'd3, 4'b1111, A_MTHI);
        check("mthi_zero", mem_rdata, 32'd0);
        @(negedge clk);
        drive(A_MTLO, 32'd0, 4'b1111, A_PRE);
        check("pre_3", mem_rdata, 32'd3);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            drive(32'd0, 32'd0, 4'd0, A_MTLO);
            check($sformatf("presc_k%0d", k), mem_rdata, 32'((k + 1) / 4));
            @(negedge clk);
        end
        drive(32'd0, 32'd0, 4'd0, A_MTLO);
        @(negedge clk);
        // Rewriting PRESCALE mid-count restarts the count from 0
        drive(A_PRE, 32'd3, 4'b1111, A_MTLO);
        check("restart_pre", mem_rdata, 32'd3);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            drive(32'd0, 32'd0, 4'd0, A_MTLO);
            check($sformatf("restart_j%0d", j), mem_rdata, (j < 4) ? 32'd3 : 32'd4);
            @(negedge clk);
        end

        // Carry from LO to HI and interrupt timing
        drive(A_PRE, 32'd0, 4'b1111, A_MTLO);
        @(negedge clk);
        drive(A_CMPLO, 32'd1, 4'b1111, A_MTLO);
        @(negedge clk);
        drive(A_CMPHI, 32'd1, 4'b1111, A_CMPLO);
        check("cmplo_1", mem_rdata, 32'd1);
        @(negedge clk);
        drive(A_MTHI, 32'd0, 4'b1111, A_CMPHI);
        check("cmphi_1", mem_rdata, 32'd1);
        @(negedge clk);
        drive(A_MTLO, 32'hFFFF_FFFF, 4'b1111, A_MTHI);
        check("mthi_pre", mem_rdata, 32'd0);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_MTHI);
        check("carry_hi0", mem_rdata, 32'd0);
        check("carry_irq0", {31'd0, timer_irq_o}, 32'd0);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_MTHI);
        check("carry_hi1", mem_rdata, 32'd1);
        check("carry_irq1", {31'd0, timer_irq_o}, 32'd0);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_MTLO);
        check("carry_lo1", mem_rdata, 32'd1);
        check("carry_irq2", {31'd0, timer_irq_o}, 32'd0);
        @(negedge clk);
        drive(A_CMPHI, 32'hFFFF_FFFF, 4'b1111, A_MTLO);
        check("carry_lo2", mem_rdata, 32'd2);
        check("irq_rise", {31'd0, timer_irq_o}, 32'd1);
        @(negedge clk);
        drive(A_CMPLO, 32'hFFFF_FFFF, 4'b1111, A_CMPHI);
        check("cmphi_ones", mem_rdata, 32'hFFFF_FFFF);
        check("irq_hold", {31'd0, timer_irq_o}, 32'd1);
        @(negedge clk);
        drive(A_PRE, 32'hABCD_1234, 4'b0110, A_CMPLO);
        check("cmplo_ones", mem_rdata, 32'hFFFF_FFFF);
        check("irq_clear", {31'd0, timer_irq_o}, 32'd0);
        @(negedge clk);

        // Reset mid-count with mtime=0x1234 and irq asserted
        drive(A_PRE, 32'hFFFF_FFFF, 4'b1111, A_PRE);
        check("pre_lanes", mem_rdata, 32'h0000_1200);
        @(negedge clk);
        drive(A_MTHI, 32'd0, 4'b1111, A_PRE);
        check("pre_ffff", mem_rdata, 32'h0000_FFFF);
        @(negedge clk);
        drive(A_MTLO, 32'h0000_1234, 4'b1111, A_MTHI);
        @(negedge clk);
        drive(A_CMPHI, 32'd0, 4'b1111, A_MTLO);
        check("mtlo_1234", mem_rdata, 32'h0000_1234);
        @(negedge clk);
        drive(A_CMPLO, 32'd0, 4'b1111, A_MTLO);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_MTLO);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_MTLO);
        check("pre_rst_irq", {31'd0, timer_irq_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mtlo", mem_rdata, 32'd0);
        check("mid_rst_gpio", gpio_o, 32'd0);
        check("mid_rst_irq", {31'd0, timer_irq_o}, 32'd0);
        mem_raddr = A_CMPLO;
        #1;
        check("mid_rst_cmplo", mem_rdata, 32'hFFFF_FFFF);
        mem_raddr = A_PRE;
        #1;
        check("mid_rst_pre", mem_rdata, 32'd0);
`else
        // Timer absent: its offsets read 0 and ignore writes
        drive(A_MTLO, 32'h0000_1234, 4'b1111, A_MTLO);
        @(negedge clk);
        drive(A_PRE, 32'd3, 4'b1111, A_MTLO);
        check("off_mtlo", mem_rdata, 32'd0);
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_PRE);
        check("off_pre", mem_rdata, 32'd0);
        check("off_irq", {31'd0, timer_irq_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gpio", gpio_o, 32'd0);
        check("mid_rst_irq", {31'd0, timer_irq_o}, 32'd0);
        mem_raddr = A_MTLO;
        #1;
        check("mid_rst_mtlo", mem_rdata, 32'd0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(32'd0, 32'd0, 4'd0, A_GPIO);
        check("post_rst_gpio", mem_rdata, 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
